// File: rtl/ram_chk_pkg.sv
// rtl/ram_chk_pkg.sv - shared state encoding, pattern codes and pattern generator for ram_host_checker
package ram_chk_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WRITE = 3'd1;
  localparam logic [2:0] ST_READ  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    WRITE = ST_WRITE,
    READ  = ST_READ,
    DRAIN = ST_DRAIN,
    DONE  = ST_DONE
  } state_t;

  localparam logic [1:0] PAT_CHECKER = 2'd0;
  localparam logic [1:0] PAT_ADDR    = 2'd1;
  localparam logic [1:0] PAT_NADDR   = 2'd2;
  localparam logic [1:0] PAT_ONES    = 2'd3;

  // Data byte expected at an address; only the low address byte matters.
  function automatic logic [7:0] pattern(input logic [1:0] sel, input logic [7:0] a);
    case (sel)
      PAT_CHECKER: pattern = a[0] ? 8'hAA : 8'h55;
      PAT_ADDR:    pattern = a;
      PAT_NADDR:   pattern = ~a;
      default:     pattern = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/rd_expect_pipe.sv
// rtl/rd_expect_pipe.sv - valid+address delay line that lines up issued read addresses with returning rd_data
module rd_expect_pipe #(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic              pending
);

  logic [RD_LAT-1:0] vld;
  logic [ADDR_W-1:0] adr [RD_LAT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld <= '0;
      for (int i = 0; i < RD_LAT; i++) adr[i] <= '0;
    end else if (flush) begin
      vld <= '0;
    end else begin
      vld[0] <= push;
      adr[0] <= push_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        vld[i] <= vld[i-1];
        adr[i] <= adr[i-1];
      end
    end
  end

  assign out_valid = vld[RD_LAT-1];
  assign out_addr  = adr[RD_LAT-1];

  // Entries still in flight once the current output has been consumed.
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < RD_LAT - 1; i++) pending = pending | vld[i];
  end

endmodule

// File: rtl/ram_host_checker.sv
// rtl/ram_host_checker.sv - write/read-back sweep checker for the Sub_BIST functional port
module ram_host_checker
  import ram_chk_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        pat_sel,
  input  logic              bist_active,
  input  logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] wrt_addrs,
  output logic [DATA_W-1:0] wrt_dat,
  output logic              wrt_en,
  output logic [ADDR_W-1:0] rd_addrs,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              aborted,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] first_err_addrs
);

  state_t            state, state_nxt;
  logic [ADDR_W:0]   cnt, cnt_inc;
  logic [1:0]        pat_q;
  logic [ADDR_W-1:0] rd_hold;
  logic              in_run, accept, abort, sweep_end;
  logic              pipe_valid, pipe_pending, mismatch;
  logic [ADDR_W-1:0] pipe_addr;
  logic [DATA_W-1:0] exp_dat;
  logic [ADDR_W:0]   err_nxt;

  assign in_run    = (state == WRITE) || (state == READ) || (state == DRAIN);
  assign accept    = ((state == IDLE) || (state == DONE)) && start && !bist_active;
  assign abort     = in_run && bist_active;
  assign cnt_inc   = cnt + (ADDR_W+1)'(1);
  // The extra counter bit flags the end of a sweep without wrapping the address.
  assign sweep_end = cnt_inc[ADDR_W];

  rd_expect_pipe #(
    .ADDR_W(ADDR_W),
    .RD_LAT(RD_LAT)
  ) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .flush    (abort || accept),
    .push     ((state == READ) && !bist_active),
    .push_addr(cnt[ADDR_W-1:0]),
    .out_valid(pipe_valid),
    .out_addr (pipe_addr),
    .pending  (pipe_pending)
  );

  assign exp_dat  = DATA_W'(pattern(pat_q, 8'(pipe_addr)));
  assign mismatch = pipe_valid && !bist_active && (rd_data != exp_dat);
  assign err_nxt  = err_count + (ADDR_W+1)'(mismatch);

  assign wrt_en    = (state == WRITE) && !bist_active;
  assign wrt_addrs = (state == WRITE) ? cnt[ADDR_W-1:0] : '0;
  assign wrt_dat   = (state == WRITE) ? DATA_W'(pattern(pat_q, 8'(cnt[ADDR_W-1:0]))) : '0;
  assign rd_addrs  = (state == READ) ? cnt[ADDR_W-1:0] : rd_hold;
  assign busy      = in_run;
  assign done      = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (accept) state_nxt = WRITE;
      WRITE:      if (sweep_end) state_nxt = READ;
      READ:       if (sweep_end) state_nxt = DRAIN;
      DRAIN:      if (!pipe_pending) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
    if (abort) state_nxt = DONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt             <= '0;
      pat_q           <= PAT_CHECKER;
      rd_hold         <= '0;
      err_count       <= '0;
      first_err_addrs <= '0;
      pass            <= 1'b0;
      fail            <= 1'b0;
      aborted         <= 1'b0;
    end else begin
      if (state == READ) rd_hold <= cnt[ADDR_W-1:0];
      if (accept) begin
        cnt             <= '0;
        pat_q           <= pat_sel;
        err_count       <= '0;
        first_err_addrs <= '0;
        pass            <= 1'b0;
        fail            <= 1'b0;
        aborted         <= 1'b0;
      end else if (abort) begin
        aborted <= 1'b1;
        fail    <= 1'b1;
        pass    <= 1'b0;
      end else begin
        if ((state == WRITE) || (state == READ)) cnt <= sweep_end ? '0 : cnt_inc;
        if (mismatch) begin
          err_count <= err_nxt;
          if (err_count == '0) first_err_addrs <= pipe_addr;
        end
        // The final compare lands on the same edge, so judge on the updated count.
        if ((state == DRAIN) && !pipe_pending) begin
          pass <= (err_nxt == '0);
          fail <= (err_nxt != '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_host_checker.sv
// tb/tb_ram_host_checker.sv - directed and randomized sweeps of ram_host_checker against a faulty-RAM model
module tb_ram_host_checker;

  localparam int AW = 10;
  localparam int DW = 8;
  localparam int RL = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    pat_sel = 2'd0;
  logic          bist_active = 1'b0;
  logic [DW-1:0] rd_data = '0;
  logic [AW-1:0] wrt_addrs;
  logic [DW-1:0] wrt_dat;
  logic          wrt_en;
  logic [AW-1:0] rd_addrs;
  logic          busy, done, pass, fail, aborted;
  logic [AW:0]   err_count;
  logic [AW-1:0] first_err_addrs;

  int total = 0;
  int bad = 0;

  logic [7:0] mem [DEPTH];
  bit         ovr_en [DEPTH];
  logic [7:0] ovr_val [DEPTH];
  logic [7:0] stuck_and = 8'hFF;
  logic [7:0] rd_s1 = '0;

  int         run_pat = 0;
  int         wr_cnt = 0;
  int         wr_bad = 0;
  logic       prev_en = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  always #5 clk = ~clk;

  ram_host_checker #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .pat_sel        (pat_sel),
    .bist_active    (bist_active),
    .rd_data        (rd_data),
    .wrt_addrs      (wrt_addrs),
    .wrt_dat        (wrt_dat),
    .wrt_en         (wrt_en),
    .rd_addrs       (rd_addrs),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .fail           (fail),
    .aborted        (aborted),
    .err_count      (err_count),
    .first_err_addrs(first_err_addrs)
  );

  function automatic logic [7:0] ref_pat(input int p, input int a);
    case (p)
      0:       return (a % 2 == 0) ? 8'h55 : 8'hAA;
      1:       return 8'(a % 256);
      2:       return 8'(255 - a % 256);
      default: return 8'hFF;
    endcase
  endfunction

  // RAM behind Sub_BIST: two-cycle read with optional per-address override and stuck bits.
  always @(posedge clk) begin
    if (wrt_en) mem[wrt_addrs] <= wrt_dat;
    rd_s1   <= (ovr_en[rd_addrs] ? ovr_val[rd_addrs] : mem[rd_addrs]) & stuck_and;
    rd_data <= rd_s1;
  end

  always @(negedge clk) begin
    if (wrt_en) begin
      if (wrt_addrs !== (prev_en ? prev_addr + 10'd1 : 10'd0) ||
          wrt_dat !== ref_pat(run_pat, int'(wrt_addrs)))
        wr_bad++;
      wr_cnt++;
    end
    prev_en   = wrt_en;
    prev_addr = wrt_addrs;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected error count and first failing address after a clean write of pattern p.
  task automatic model(input int p, output int e, output int f);
    logic [7:0] v;
    e = 0;
    f = 0;
    for (int a = 0; a < DEPTH; a++) begin
      v = (ovr_en[a] ? ovr_val[a] : ref_pat(p, a)) & stuck_and;
      if (v != ref_pat(p, a)) begin
        if (e == 0) f = a;
        e++;
      end
    end
  endtask

  task automatic run(input logic [1:0] p, input bit poke, output int lat, output int nwr, output int nbad);
    int wc0, wb0;
    wc0 = wr_cnt;
    wb0 = wr_bad;
    @(negedge clk);
    start   = 1'b1;
    pat_sel = p;
    run_pat = int'(p);
    @(negedge clk);
    start   = 1'b0;
    pat_sel = 2'($urandom);
    chk("start_clears_done", done, 0);
    chk("start_busy", busy, 1);
    chk("start_clears_err", err_count, 0);
    lat = 0;
    while (!done && lat < 5000) begin
      @(negedge clk);
      lat++;
      start = poke && (lat == 1500);
    end
    start = 1'b0;
    chk("done_seen", done, 1);
    nwr  = wr_cnt - wc0;
    nbad = wr_bad - wb0;
  endtask

  initial begin
    int lat, nwr, nbad, e_err, e_first, n, a;
    logic [1:0] p;

    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = 8'($urandom);
      ovr_en[i]  = 1'b0;
      ovr_val[i] = 8'h00;
    end

    repeat (3) @(negedge clk);
    chk("rst_wrt_en", wrt_en, 0);
    chk("rst_wrt_addrs", wrt_addrs, 0);
    chk("rst_wrt_dat", wrt_dat, 0);
    chk("rst_rd_addrs", rd_addrs, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_flags", {pass, fail, aborted}, 0);
    chk("rst_err", err_count, 0);
    chk("rst_first", first_err_addrs, 0);
    rst = 1'b1;

    run(2'd1, 1'b0, lat, nwr, nbad);
    chk("clean_lat", lat, 2 * DEPTH + RL);
    chk("clean_writes", nwr, DEPTH);
    chk("clean_wr_bad", nbad, 0);
    chk("clean_pass", {pass, fail, aborted}, 3'b100);
    chk("clean_err", err_count, 0);

    ovr_en[10'h12C]  = 1'b1;
    ovr_val[10'h12C] = 8'h00;
    run(2'd0, 1'b0, lat, nwr, nbad);
    chk("corrupt_err", err_count, 1);
    chk("corrupt_first", first_err_addrs, 10'h12C);
    chk("corrupt_flags", {pass, fail}, 2'b01);
    chk("corrupt_wr_bad", nbad, 0);
    ovr_en[10'h12C] = 1'b0;

    stuck_and = 8'hFE;
    run(2'd3, 1'b0, lat, nwr, nbad);
    chk("stuck_err", err_count, DEPTH);
    chk("stuck_first", first_err_addrs, 0);
    chk("stuck_fail", fail, 1);
    chk("stuck_lat", lat, 2 * DEPTH + RL);
    stuck_and = 8'hFF;

    for (int r = 0; r < 3; r++) begin
      p = 2'($urandom_range(0, 3));
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        a = $urandom_range(0, DEPTH - 1);
        ovr_en[a]  = 1'b1;
        ovr_val[a] = 8'($urandom);
      end
      model(int'(p), e_err, e_first);
      run(p, 1'b0, lat, nwr, nbad);
      chk("rand_err", err_count, e_err);
      chk("rand_first", first_err_addrs, e_first);
      chk("rand_pass", {pass, fail}, (e_err == 0) ? 2'b10 : 2'b01);
      chk("rand_wr_bad", nbad, 0);
      for (int i = 0; i < DEPTH; i++) ovr_en[i] = 1'b0;
    end

    // Abort during WRITE: the write strobe must drop in the same cycle.
    @(negedge clk);
    start = 1'b1; pat_sel = 2'd1; run_pat = 1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    chk("wabort_pre_wrt_en", wrt_en, 1);
    bist_active = 1'b1;
    #1;
    chk("wabort_wrt_en", wrt_en, 0);
    @(negedge clk);
    chk("wabort_done", {done, aborted, fail, pass}, 4'b1110);
    bist_active = 1'b0;

    // Abort during READ at address 500.
    @(negedge clk);
    start = 1'b1; pat_sel = 2'd1; run_pat = 1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(busy && !wrt_en && rd_addrs == 10'd500) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("rabort_reach", rd_addrs, 500);
    bist_active = 1'b1;
    @(negedge clk);
    chk("rabort_flags", {done, aborted, fail, pass, busy}, 5'b11100);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rabort_start_ignored", {done, aborted, busy}, 3'b110);
    repeat (3) @(negedge clk);
    chk("rabort_rd_hold", rd_addrs, 500);
    chk("rabort_wrt_en", wrt_en, 0);
    bist_active = 1'b0;

    // Asynchronous reset in the middle of WRITE at address 300.
    @(negedge clk);
    start = 1'b1; pat_sel = 2'd2; run_pat = 2;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(wrt_en && wrt_addrs == 10'd300) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_reach", wrt_addrs, 300);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_wrt", {wrt_en, wrt_addrs, wrt_dat}, 0);
    chk("rst_mid_rd_addrs", rd_addrs, 0);
    chk("rst_mid_state", {busy, done, pass, fail, aborted}, 0);
    @(negedge clk);
    rst = 1'b1;
    run(2'd2, 1'b0, lat, nwr, nbad);
    chk("rerun_writes", nwr, DEPTH);
    chk("rerun_wr_bad", nbad, 0);
    chk("rerun_pass", {pass, err_count}, {1'b1, 11'd0});

    // start during READ is ignored; start in DONE reruns from clean.
    ovr_en[7]  = 1'b1;
    ovr_val[7] = 8'h00;
    run(2'd1, 1'b1, lat, nwr, nbad);
    chk("poke_lat", lat, 2 * DEPTH + RL);
    chk("poke_err", err_count, 1);
    chk("poke_first", first_err_addrs, 7);
    ovr_en[7] = 1'b0;
    run(2'd1, 1'b0, lat, nwr, nbad);
    chk("second_pass", {pass, fail, err_count}, {2'b10, 11'd0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
